// File: rtl/acc_drain_if.sv
// Handshake/bus bundle between acc_drain_ctrl, the top-level controller,
// the accumulator array and the result writeback path.
interface acc_drain_if #(
    parameter int DW     = 32,
    parameter int TILE_W = 3,
    parameter int ROW_W  = 2
);
    logic              start;
    logic              acc_rd_en;
    logic [TILE_W-1:0] acc_rd_tile;
    logic [ROW_W-1:0]  acc_rd_row;
    logic [DW-1:0]     acc_rd_data;
    logic              acc_clr;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic              out_ready;
    logic              busy;
    logic              done;

    // Result stream is valid/ready: a word transfers on a cycle with
    // out_valid & out_ready; while out_valid=1 and out_ready=0 the word
    // (out_data, out_last) is held unchanged.
    modport master (
        input  start,
        output acc_rd_en, acc_rd_tile, acc_rd_row,
        input  acc_rd_data,
        output acc_clr,
        output out_valid, out_data, out_last,
        input  out_ready,
        output busy, done
    );

    modport slave (
        output start,
        input  acc_rd_en, acc_rd_tile, acc_rd_row,
        output acc_rd_data,
        input  acc_clr,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  busy, done
    );
endinterface

// File: rtl/acc_drain_ctrl.sv
// Walks every accumulator tile/row, issues single-cycle reads, buffers the
// returned words in a 2-entry FIFO and clears each tile once it has been read.
module acc_drain_ctrl #(
    parameter int N      = 8,
    parameter int ROWS   = 4,
    parameter int DW     = 32,
    parameter int TILE_W = 3,
    parameter int ROW_W  = 2
) (
    input  logic        clk,
    input  logic        rst,
    acc_drain_if.master bus,
    output logic [2:0]  dbg_state
);
    localparam int NUM_TILES = N / 4;
    localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CLEAR = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic [DW-1:0]     fifo_data_q [2];
    logic [DW-1:0]     fifo_data_d [2];
    logic [1:0]        fifo_last_q, fifo_last_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    logic       push;
    logic       pop;
    logic       credit_ok;
    logic       issue;
    logic [2:0] occupancy;

    assign push = inflight_q;
    assign pop  = (count_q != 2'd0) && bus.out_ready;

    // Words already buffered plus the one still on its way back from the
    // array, minus the one leaving this cycle, must leave a free FIFO slot.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok = occupancy < 3'd2;
    assign issue     = (state_q == S_READ) && credit_ok;

    always_comb begin
        state_d         = state_q;
        tile_d          = tile_q;
        row_d           = row_q;
        inflight_d      = issue;
        inflight_last_d = issue && (tile_q == LAST_TILE) && (row_q == LAST_ROW);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_READ;
                    tile_d  = '0;
                    row_d   = '0;
                end
            end
            S_READ: begin
                if (credit_ok) begin
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        state_d = S_CLEAR;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            S_CLEAR: begin
                if (tile_q == LAST_TILE) begin
                    state_d = S_DRAIN;
                end else begin
                    tile_d  = tile_q + TILE_W'(1);
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                if (pop && bus.out_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read data arrives one cycle after the strobe and is written straight in;
    // the head entry is presented directly (first-word-fall-through).
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = bus.acc_rd_data;
            fifo_last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            tile_q          <= '0;
            row_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q     <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            tile_q          <= tile_d;
            row_q           <= row_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
        end
    end

    assign bus.acc_rd_en   = issue;
    assign bus.acc_rd_tile = tile_q;
    assign bus.acc_rd_row  = row_q;
    assign bus.acc_clr     = (state_q == S_CLEAR);
    assign bus.out_valid   = (count_q != 2'd0);
    assign bus.out_data    = fifo_data_q[rd_ptr_q];
    assign bus.out_last    = fifo_last_q[rd_ptr_q] && (count_q != 2'd0);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_acc_drain_ctrl.sv
// Bench for acc_drain_ctrl: accumulator array model, randomized backpressure,
// expected-word queue and per-cycle checks of the drain protocol.
module tb_acc_drain_ctrl;
  localparam int N      = 8;
  localparam int ROWS   = 4;
  localparam int DW     = 32;
  localparam int TILE_W = 3;
  localparam int ROW_W  = 2;
  localparam int NT     = N / 4;
  localparam int TOTAL  = NT * ROWS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acc_drain_if #(.DW(DW), .TILE_W(TILE_W), .ROW_W(ROW_W)) bus ();
  logic [2:0] dbg_state;

  acc_drain_ctrl #(.N(N), .ROWS(ROWS), .DW(DW), .TILE_W(TILE_W), .ROW_W(ROW_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW:0]   exp_q[$];          // {last, data}
  logic [DW-1:0] acc_mem [NT][ROWS];
  logic [DW-1:0] next_base;
  int  rd_idx, clr_idx, iss_cnt, iss_prev, pop_cnt, done_cnt;
  bit  act, prev_v, prev_r, prev_last, last_hs_prev;
  logic [DW-1:0] prev_d;
  bit  pend_v;
  logic [DW-1:0] pend_d;
  int  ready_mode;
  int  fifo_occ;
  logic [DW:0] exp_word;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Accumulator array: returns the word latched at issue time one cycle later.
  initial begin
    bus.acc_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pend_v) begin
        bus.acc_rd_data = pend_d;
        pend_v = 1'b0;
      end else begin
        bus.acc_rd_data = $urandom;
      end
    end
  end

  // Reference model and per-cycle compare, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      rd_idx = 0; clr_idx = 0; iss_cnt = 0; iss_prev = 0; pop_cnt = 0;
      act = 0; prev_v = 0; prev_r = 0; last_hs_prev = 0; pend_v = 0;
    end else begin
      // words in the FIFO = reads issued two or more cycles ago minus words accepted
      fifo_occ = iss_prev - pop_cnt;
      check("fifo_occ_le2", 64'(fifo_occ <= 2), 64'd1);
      check("out_valid", 64'(bus.out_valid), 64'(fifo_occ != 0));
      check("busy", 64'(bus.busy), 64'(act));
      if (prev_v && !prev_r) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_word", 64'({bus.out_last, bus.out_data}), 64'({prev_last, prev_d}));
      end
      if (bus.acc_rd_en) begin
        check("rd_in_range", 64'(rd_idx < TOTAL), 64'd1);
        check("rd_addr", 64'({bus.acc_rd_tile, bus.acc_rd_row}),
              64'(((rd_idx / ROWS) << ROW_W) | (rd_idx % ROWS)));
        if (int'(bus.acc_rd_tile) < NT && int'(bus.acc_rd_row) < ROWS)
          pend_d = acc_mem[bus.acc_rd_tile][bus.acc_rd_row];
        else
          pend_d = '0;
        pend_v = 1'b1;
        rd_idx++;
      end
      if (bus.acc_clr) begin
        check("clr_tile", 64'(bus.acc_rd_tile), 64'(clr_idx));
        check("clr_after_reads", 64'(rd_idx), 64'((clr_idx + 1) * ROWS));
        check("clr_no_read", 64'(bus.acc_rd_en), 64'd0);
        if (int'(bus.acc_rd_tile) < NT)
          for (int r = 0; r < ROWS; r++) acc_mem[bus.acc_rd_tile][r] = '0;
        clr_idx++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 64'(bus.out_data), 64'hdead);
        end else begin
          exp_word = exp_q.pop_front();
          check("out_word", 64'({bus.out_last, bus.out_data}), 64'(exp_word));
        end
        pop_cnt++;
      end
      if (bus.done) begin
        check("done_after_last", 64'(last_hs_prev), 64'd1);
        check("done_all_words", 64'(exp_q.size()), 64'd0);
        done_cnt++;
      end
      if (bus.done) begin
        act = 0;
      end else if (!act && bus.start) begin
        act = 1;
        rd_idx = 0;
        clr_idx = 0;
        for (int t = 0; t < NT; t++)
          for (int r = 0; r < ROWS; r++) begin
            acc_mem[t][r] = next_base + DW'(t * 16 + r);
            exp_q.push_back({1'(t == NT - 1 && r == ROWS - 1), next_base + DW'(t * 16 + r)});
          end
      end
      iss_prev = iss_cnt;
      if (bus.acc_rd_en) iss_cnt++;
      prev_v = bus.out_valid;
      prev_r = bus.out_ready;
      prev_d = bus.out_data;
      prev_last = bus.out_last;
      last_hs_prev = bus.out_valid && bus.out_ready && bus.out_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 500) begin
      step();
      n++;
    end
    check(name, 64'(done_cnt == d0), 64'd0);
  endtask

  task automatic run_drain(input logic [DW-1:0] base, input int mode);
    int d0;
    d0 = done_cnt;
    ready_mode = mode;
    next_base = base;
    step();
    bus.start = 1'b1;
    wait_done(d0, "drain_timeout");
  endtask

  function automatic logic [15:0] mask(input int lo, input int hi);
    logic [15:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // ---------------- stimulus ----------------
  logic [15:0] s_rd, s_clr, s_v, s_last, s_done, s_busy;
  int d0, p0, i0;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    ready_mode = 0;
    next_base = '0;
    done_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({bus.acc_rd_en, bus.acc_rd_tile, bus.acc_rd_row, bus.acc_clr,
                                bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.done}), 64'd0);
    rst = 1'b0;
    repeat (2) step();

    // Directed timing with out_ready=1, start in cycle 0, pattern tile*16+row.
    ready_mode = 0;
    next_base = '0;
    d0 = done_cnt;
    for (int c = 0; c < 14; c++) begin
      step();
      if (c == 0) bus.start = 1'b1;
      @(negedge clk);
      s_rd[c] = bus.acc_rd_en; s_clr[c] = bus.acc_clr; s_v[c] = bus.out_valid;
      s_last[c] = bus.out_last; s_done[c] = bus.done; s_busy[c] = bus.busy;
    end
    check("timing_rd_en", 64'(s_rd[13:0]), 64'(mask(1, 4) | mask(6, 9)));
    check("timing_clr", 64'(s_clr[13:0]), 64'(mask(5, 5) | mask(10, 10)));
    check("timing_valid", 64'(s_v[13:0]), 64'(mask(3, 6) | mask(8, 11)));
    check("timing_last", 64'(s_last[13:0]), 64'(mask(11, 11)));
    check("timing_done", 64'(s_done[13:0]), 64'(mask(12, 12)));
    check("timing_busy", 64'(s_busy[13:0]), 64'(mask(1, 12)));
    check("timing_one_done", 64'(done_cnt - d0), 64'd1);

    // Backpressure from cycle 2: exactly two reads get out, then release.
    d0 = done_cnt; p0 = pop_cnt; i0 = iss_cnt;
    ready_mode = 0;
    next_base = 32'h0001_0000;
    step();
    bus.start = 1'b1;
    step();
    ready_mode = 2;
    repeat (12) step();
    check("stall_reads", 64'(iss_cnt - i0), 64'd2);
    check("stall_no_pop", 64'(pop_cnt - p0), 64'd0);
    ready_mode = 0;
    wait_done(d0, "stall_timeout");
    check("stall_words", 64'(pop_cnt - p0), 64'(TOTAL));

    // Second start pulse at cycle 5 of a drain is ignored.
    d0 = done_cnt; p0 = pop_cnt;
    ready_mode = 0;
    next_base = 32'h0002_0000;
    step();
    bus.start = 1'b1;
    repeat (5) step();
    bus.start = 1'b1;
    wait_done(d0, "restart_timeout");
    repeat (6) step();
    check("restart_one_done", 64'(done_cnt - d0), 64'd1);
    check("restart_words", 64'(pop_cnt - p0), 64'(TOTAL));

    // Randomized backpressure over 20 drains.
    d0 = done_cnt; p0 = pop_cnt;
    for (int k = 0; k < 20; k++) begin
      run_drain($urandom, 1);
      repeat ($urandom_range(0, 3)) step();
    end
    check("rand_dones", 64'(done_cnt - d0), 64'd20);
    check("rand_words", 64'(pop_cnt - p0), 64'(20 * TOTAL));

    // Asynchronous reset at cycle 7 of a drain, then a clean drain.
    ready_mode = 0;
    next_base = 32'h0003_0000;
    step();
    bus.start = 1'b1;
    repeat (7) step();
    rst = 1'b1;
    #1;
    check("async_reset_outputs", 64'({bus.acc_rd_en, bus.acc_rd_tile, bus.acc_rd_row, bus.acc_clr,
                                      bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.done}), 64'd0);
    repeat (2) step();
    rst = 1'b0;
    step();
    d0 = done_cnt; p0 = pop_cnt;
    run_drain(32'h0004_0000, 1);
    check("post_reset_words", 64'(pop_cnt - p0), 64'(TOTAL));
    check("post_reset_done", 64'(done_cnt - d0), 64'd1);
    repeat (4) step();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
